interrupt_pc_sequencer: RTL and testbench
=========================================

# interrupt_pc_sequencer

Downstream consumer of the interrupt controller's `s_interruption` / `dir_out` pair. It converts an interrupt request into a PC redirect, saving the interrupted PC on a small return-address stack. On a decoded return-from-interrupt it restores that PC and pulses `s_finished` back to the interrupt controller, so the controller can clear the serviced source. The block sits between the interrupt controller and the fetch-stage PC register.

## Interface
- `DEPTH`, 4: return-stack entries (maximum nesting level), 1..8.
- `AW`, 10: address width; matches the controller's `dir_out`.
- `NEST`, 0: 1 = accept a new request while an ISR is active; 0 = hold it pending until return.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `s_interruption`  in  1  request from the interrupt controller; rising edge detected on `clk`.
- `dir_in`  in  AW  ISR entry address; valid in the cycle the `s_interruption` edge is detected.
- `pc_current`  in  AW  address the CPU would fetch next (the return address).
- `i_reti`  in  1  return-from-interrupt decoded; one-cycle pulse.
- `pc_load`  out  1  one-cycle strobe; PC register loads `pc_target`.
- `pc_target`  out  AW  redirect address; valid while `pc_load`=1.
- `s_finished`  out  1  one-cycle pulse to the interrupt controller on each completed return.
- `in_isr`  out  1  high while `depth` > 0.
- `depth`  out  4  current stack occupancy, 0..DEPTH.
- `err_ovf`  out  1  one-cycle pulse: request dropped because the stack is full.
- `err_unf`  out  1  one-cycle pulse: `i_reti` rejected (empty stack, or arrived in ENTER/LEAVE).

## Operation
- Edge detect: `req` = `s_interruption` AND NOT `s_interruption_q`.
  - `s_interruption_q` is a registered copy of `s_interruption`, cleared by reset.
- Pending latch: one entry, holding `pend_v` and `pend_addr`.
- FSM states: IDLE, ENTER, ACTIVE, LEAVE.
- IDLE:
  - On `req`, go to ENTER.
  - Capture `dir_in` → `tgt`.
  - Capture `pc_current` → `ret`.
- ENTER (1 cycle):
  - Push `ret` at `stack[depth]`; `depth`+1.
  - Drive `pc_load`=1, `pc_target`=`tgt`.
  - Go to ACTIVE.
- ACTIVE:
  - `i_reti` with `depth`>0: pop into `tgt`, go to LEAVE.
  - `req` with NEST=1 and `depth`<DEPTH: capture as in IDLE, go to ENTER.
  - `req` with NEST=1 and `depth`=DEPTH: drop the request, pulse `err_ovf`.
  - `req` with NEST=0: latch it in pending.
- LEAVE (1 cycle):
  - Drive `pc_load`=1, `pc_target`=popped value, `s_finished`=1; `depth`−1.
  - If `pend_v`=1: go to ENTER with `tgt`=`pend_addr` and `ret`=`pc_current` sampled in the cycle after LEAVE. This is the restored PC; ENTER is therefore delayed one cycle via IDLE.
  - Otherwise: go to IDLE when the new `depth`=0, else ACTIVE.
- `req` arriving in ENTER or LEAVE always goes to pending.
- `req` arriving while `pend_v`=1 already: the new address overwrites `pend_addr`. The controller guarantees priority order.
- IDLE with `pend_v`=1: treated as `req` using `pend_addr`; clears `pend_v`.
- `i_reti` in IDLE, ENTER or LEAVE: ignored; pulse `err_unf`.
- Simultaneous `i_reti` and `req` in ACTIVE: the return wins; the request goes to pending.
- Stack is LIFO, AW bits wide, and is not cleared by reset. Only `depth` defines validity.

## Timing
- Reset values (sampled at `clk`):
  - `pc_load`, `s_finished`, `err_ovf`, `err_unf`, `in_isr`, `pend_v`: 0.
  - `depth`: 0.
  - `pc_target`: 0.
  - State: IDLE.
- Reset asserted mid-ISR discards the stack and pending request; no `s_finished` is emitted.
- Entry latency: `req` detected at edge N → `pc_load`=1 during cycle N+1.
- Return latency: `i_reti` sampled at edge M → `pc_load`=1 and `s_finished`=1 during cycle M+1.
- Pending after return: ENTER occurs at M+3 (LEAVE at M+1, IDLE at M+2).
- All outputs are registered; there is no combinational path from input to output.
- `pc_target` holds its last value when `pc_load`=0.

## Test plan
- Reset check: hold `reset` for 2 cycles mid-ISR with `depth`=2 → all outputs 0 on the next edge; a subsequent `i_reti` → `err_unf`=1, no `pc_load`.
- Single interrupt:
  - `pc_current`=0x050, `dir_in`=0x012, pulse `s_interruption` → next cycle `pc_load`=1, `pc_target`=0x012, `depth`=1.
  - Then `i_reti` → `pc_target`=0x050, `s_finished`=1 for exactly 1 cycle, `depth`=0.
- NEST=0 pending:
  - In ISR, request with `dir_in`=0x3FC → no load.
  - `i_reti` → return load, then two cycles later `pc_target`=0x3FC; the pushed return address is the restored PC.
- NEST=1, DEPTH=2 overflow: three requests → two loads, `depth`=2, third gives `err_ovf`=1. Then two `i_reti` → LIFO return order.
- Collision: `i_reti` and a request edge in the same ACTIVE cycle → return first, `s_finished`=1, then entry to the pending address.
- Held level: `s_interruption` held high for 5 cycles → exactly one entry, since entry is edge-triggered.

Source files
------------

// File: rtl/interrupt_pc_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_pc_sequencer
//
// Sits between the interrupt controller and the fetch-stage PC register.
// Turns an interrupt request into a PC redirect. The interrupted PC is saved on
// a small LIFO return stack. A decoded return-from-interrupt restores that PC
// and tells the controller the source has been serviced.
//
// Parameters
//   DEPTH  return-stack entries / maximum nesting level (1..8)
//   AW     address width (matches the controller's dir_out)
//   NEST   1: accept a new request while an ISR is active
//          0: hold it pending until the ISR returns
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   s_interruption request level from the controller (rising edge = request)
//   dir_in         ISR entry address, valid in the cycle the edge is detected
//   pc_current     address the CPU would fetch next (the return address)
//   i_reti         return-from-interrupt decoded (one-cycle pulse)
//   pc_load        one-cycle strobe: PC register loads pc_target
//   pc_target      redirect address, held while pc_load is low
//   s_finished     one-cycle pulse to the controller on each completed return
//   in_isr         high while depth > 0
//   depth          current stack occupancy (0..DEPTH)
//   err_ovf        one-cycle pulse: request dropped, stack full
//   err_unf        one-cycle pulse: i_reti rejected (not in ACTIVE)
//
// Interface protocol: there is no valid/ready back-pressure. Every input event
// (s_interruption rising edge, i_reti pulse) is accepted unconditionally in the
// cycle it is sampled. Every output event (pc_load, s_finished, err_ovf,
// err_unf) is a registered single-cycle strobe, and the consumer must act on it
// in that cycle. pc_target is only meaningful while pc_load is high.
// -----------------------------------------------------------------------------
module interrupt_pc_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int NEST  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_interruption,
  input  logic [AW-1:0] dir_in,
  input  logic [AW-1:0] pc_current,
  input  logic          i_reti,
  output logic          pc_load,
  output logic [AW-1:0] pc_target,
  output logic          s_finished,
  output logic          in_isr,
  output logic [3:0]    depth,
  output logic          err_ovf,
  output logic          err_unf
);

  localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);
  localparam bit         NEST_EN   = (NEST != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_LEAVE  = 2'd3
  } state_t;

  state_t        state, state_d;

  logic          s_int_q;
  logic          req;

  // Sized for the largest legal DEPTH, so the index is always exactly 3 bits.
  // Entries are not reset; only depth says which ones are valid.
  logic [AW-1:0] stack [8];

  logic          pend_v, pend_v_d;
  logic [AW-1:0] pend_addr, pend_addr_d;

  logic [3:0]    depth_d;
  logic          pc_load_d, s_finished_d, err_ovf_d, err_unf_d;
  logic [AW-1:0] pc_target_d;

  logic          start_entry;
  logic [AW-1:0] entry_addr;
  logic          push_en;
  logic [2:0]    push_idx, top_idx;

  assign req      = s_interruption & ~s_int_q;
  assign push_idx = depth[2:0];
  // With DEPTH=8 and a full stack depth[2:0] wraps to 0, so top_idx is 7.
  assign top_idx  = depth[2:0] - 3'd1;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic. All outputs are registered, so the values
  // computed here describe what is visible during the cycle after the edge:
  // the cycle spent in ENTER shows the entry load, the cycle in LEAVE shows the
  // return load.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state;
    depth_d      = depth;
    pend_v_d     = pend_v;
    pend_addr_d  = pend_addr;
    pc_load_d    = 1'b0;
    pc_target_d  = pc_target;
    s_finished_d = 1'b0;
    err_ovf_d    = 1'b0;
    err_unf_d    = 1'b0;
    start_entry  = 1'b0;
    entry_addr   = dir_in;
    push_en      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_reti) err_unf_d = 1'b1;
        // A fresh edge is the newest request, so it supersedes a pending one
        // (the same overwrite rule as a second request while pending).
        if (req) begin
          start_entry = 1'b1;
          entry_addr  = dir_in;
          pend_v_d    = 1'b0;
        end else if (pend_v) begin
          start_entry = 1'b1;
          entry_addr  = pend_addr;
          pend_v_d    = 1'b0;
        end
      end

      ST_ENTER: begin
        state_d = ST_ACTIVE;
        if (i_reti) err_unf_d = 1'b1;
        if (req) begin
          pend_v_d    = 1'b1;
          pend_addr_d = dir_in;
        end
      end

      ST_ACTIVE: begin
        if (i_reti) begin
          // Return wins over a simultaneous request; the request is parked.
          state_d      = ST_LEAVE;
          pc_load_d    = 1'b1;
          pc_target_d  = stack[top_idx];
          s_finished_d = 1'b1;
          depth_d      = depth - 4'd1;
          if (req) begin
            pend_v_d    = 1'b1;
            pend_addr_d = dir_in;
          end
        end else if (req) begin
          if (!NEST_EN) begin
            pend_v_d    = 1'b1;
            pend_addr_d = dir_in;
          end else if (depth < DEPTH_MAX) begin
            start_entry = 1'b1;
            entry_addr  = dir_in;
          end else begin
            err_ovf_d = 1'b1;
          end
        end
      end

      ST_LEAVE: begin
        if (i_reti) err_unf_d = 1'b1;
        // A pending request goes through IDLE so that the return address pushed
        // for it is the restored PC, which the CPU presents one cycle later.
        if (pend_v)              state_d = ST_IDLE;
        else if (depth == 4'd0)  state_d = ST_IDLE;
        else                     state_d = ST_ACTIVE;
        if (req) begin
          pend_v_d    = 1'b1;
          pend_addr_d = dir_in;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (start_entry) begin
      state_d     = ST_ENTER;
      push_en     = 1'b1;
      depth_d     = depth + 4'd1;
      pc_load_d   = 1'b1;
      pc_target_d = entry_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      s_int_q    <= 1'b0;
      depth      <= 4'd0;
      pend_v     <= 1'b0;
      pend_addr  <= '0;
      pc_load    <= 1'b0;
      pc_target  <= '0;
      s_finished <= 1'b0;
      err_ovf    <= 1'b0;
      err_unf    <= 1'b0;
      in_isr     <= 1'b0;
    end else begin
      state      <= state_d;
      s_int_q    <= s_interruption;
      depth      <= depth_d;
      pend_v     <= pend_v_d;
      pend_addr  <= pend_addr_d;
      pc_load    <= pc_load_d;
      pc_target  <= pc_target_d;
      s_finished <= s_finished_d;
      err_ovf    <= err_ovf_d;
      err_unf    <= err_unf_d;
      in_isr     <= (depth_d != 4'd0);
    end
  end

  // Return stack storage: no reset, written only on an entry.
  always_ff @(posedge clk) begin
    if (push_en) stack[push_idx] <= pc_current;
  end

endmodule

// File: tb/tb_interrupt_pc_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for interrupt_pc_sequencer.
// Two instances share all inputs:
//   dut0: DEPTH=4, NEST=0 (requests during an ISR are held pending)
//   dut1: DEPTH=2, NEST=1 (nesting, with overflow at two levels)
// Inputs change 1 time unit after a rising edge; outputs are read 1 time unit
// after the next rising edge, when they reflect the inputs just sampled.
// -----------------------------------------------------------------------------
module tb_interrupt_pc_sequencer;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_interruption;
  logic [AW-1:0] dir_in;
  logic [AW-1:0] pc_current;
  logic          i_reti;

  logic          o0_pc_load, o0_s_finished, o0_in_isr, o0_err_ovf, o0_err_unf;
  logic [AW-1:0] o0_pc_target;
  logic [3:0]    o0_depth;
  logic          o1_pc_load, o1_s_finished, o1_in_isr, o1_err_ovf, o1_err_unf;
  logic [AW-1:0] o1_pc_target;
  logic [3:0]    o1_depth;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  interrupt_pc_sequencer #(.DEPTH(4), .AW(AW), .NEST(0)) dut0 (
    .clk(clk), .reset(reset), .s_interruption(s_interruption), .dir_in(dir_in),
    .pc_current(pc_current), .i_reti(i_reti), .pc_load(o0_pc_load),
    .pc_target(o0_pc_target), .s_finished(o0_s_finished), .in_isr(o0_in_isr),
    .depth(o0_depth), .err_ovf(o0_err_ovf), .err_unf(o0_err_unf)
  );

  interrupt_pc_sequencer #(.DEPTH(2), .AW(AW), .NEST(1)) dut1 (
    .clk(clk), .reset(reset), .s_interruption(s_interruption), .dir_in(dir_in),
    .pc_current(pc_current), .i_reti(i_reti), .pc_load(o1_pc_load),
    .pc_target(o1_pc_target), .s_finished(o1_s_finished), .in_isr(o1_in_isr),
    .depth(o1_depth), .err_ovf(o1_err_ovf), .err_unf(o1_err_unf)
  );

  // ---------------------------------------------------------------------------
  // Reference model. Described by what each instance is showing this cycle:
  // an entry redirect, a return redirect, the one quiet cycle after a return
  // that has a request waiting, or nothing. The return stack is an array with
  // a count; requests are edges of s_interruption.
  // ---------------------------------------------------------------------------
  int            m_nest [2] = '{0, 1};
  int            m_cap  [2] = '{4, 2};
  logic [AW-1:0] m_stk  [2][8];
  int            m_cnt  [2];
  bit            m_pend [2];
  logic [AW-1:0] m_pend_addr [2];
  bit            m_show_entry [2];
  bit            m_show_ret   [2];
  bit            m_gap        [2];
  bit            m_prev_s     [2];
  bit            e_load [2], e_fin [2], e_ovf [2], e_unf [2];
  logic [AW-1:0] e_tgt  [2];

  task automatic model_step(input int k);
    bit            rq, idle_like, active, was_pend, new_entry, new_ret, new_gap;
    logic [AW-1:0] entry_addr;
    if (reset) begin
      m_cnt[k] = 0; m_pend[k] = 0; m_show_entry[k] = 0; m_show_ret[k] = 0;
      m_gap[k] = 0; m_prev_s[k] = 0;
      e_load[k] = 0; e_fin[k] = 0; e_ovf[k] = 0; e_unf[k] = 0; e_tgt[k] = '0;
      return;
    end
    rq          = s_interruption && !m_prev_s[k];
    m_prev_s[k] = s_interruption;
    idle_like   = m_gap[k] || (!m_show_entry[k] && !m_show_ret[k] && m_cnt[k] == 0);
    active      = !idle_like && !m_show_entry[k] && !m_show_ret[k];
    was_pend    = m_pend[k];
    new_entry = 0; new_ret = 0; new_gap = 0; entry_addr = dir_in;
    e_fin[k] = 0; e_ovf[k] = 0;
    e_unf[k] = i_reti && !active;
    if (idle_like) begin
      if (rq || m_pend[k]) begin
        new_entry  = 1;
        entry_addr = rq ? dir_in : m_pend_addr[k];
        m_pend[k]  = 0;
      end
    end else if (active && i_reti) begin
      m_cnt[k]  = m_cnt[k] - 1;
      e_tgt[k]  = m_stk[k][m_cnt[k]];
      new_ret   = 1;
      e_fin[k]  = 1;
      if (rq) begin m_pend[k] = 1; m_pend_addr[k] = dir_in; end
    end else if (active && rq && m_nest[k] != 0) begin
      if (m_cnt[k] < m_cap[k]) new_entry = 1;
      else e_ovf[k] = 1;
    end else if (rq) begin
      m_pend[k] = 1; m_pend_addr[k] = dir_in;
    end
    if (m_show_ret[k]) new_gap = was_pend;
    if (new_entry) begin
      m_stk[k][m_cnt[k]] = pc_current;
      m_cnt[k]           = m_cnt[k] + 1;
      e_tgt[k]           = entry_addr;
    end
    e_load[k]       = new_entry || new_ret;
    m_show_entry[k] = new_entry;
    m_show_ret[k]   = new_ret;
    m_gap[k]        = new_gap;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; s_interruption = 1'b0; i_reti = 1'b0;
    dir_in = '0; pc_current = '0;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  task automatic pulse_req(input logic [AW-1:0] addr, input logic [AW-1:0] pc);
    dir_in = addr; pc_current = pc; s_interruption = 1'b1;
    cycle();
    s_interruption = 1'b0;
  endtask

  task automatic pulse_reti();
    i_reti = 1'b1;
    cycle();
    i_reti = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks++; if ({o0_pc_load, o0_pc_target, o0_s_finished, o0_err_ovf, o0_err_unf, o0_in_isr, o0_depth} !== '0) begin failures++; $display("FAIL reset_init0 got=%h exp=0", {o0_pc_load, o0_pc_target, o0_s_finished, o0_err_ovf, o0_err_unf, o0_in_isr, o0_depth}); end
    checks++; if ({o1_pc_load, o1_pc_target, o1_s_finished, o1_err_ovf, o1_err_unf, o1_in_isr, o1_depth} !== '0) begin failures++; $display("FAIL reset_init1 got=%h exp=0", {o1_pc_load, o1_pc_target, o1_s_finished, o1_err_ovf, o1_err_unf, o1_in_isr, o1_depth}); end
    pulse_req(10'h100, 10'h020);
    cycle();
    pulse_req(10'h101, 10'h021);
    checks++; if (o1_depth !== 4'd2) begin failures++; $display("FAIL reset_pre_depth1 got=%0d exp=2", o1_depth); end
    cycle();
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    checks++; if ({o0_pc_load, o0_pc_target, o0_s_finished, o0_err_ovf, o0_err_unf, o0_in_isr, o0_depth} !== '0) begin failures++; $display("FAIL reset_mid0 got=%h exp=0", {o0_pc_load, o0_pc_target, o0_s_finished, o0_err_ovf, o0_err_unf, o0_in_isr, o0_depth}); end
    checks++; if ({o1_pc_load, o1_pc_target, o1_s_finished, o1_err_ovf, o1_err_unf, o1_in_isr, o1_depth} !== '0) begin failures++; $display("FAIL reset_mid1 got=%h exp=0", {o1_pc_load, o1_pc_target, o1_s_finished, o1_err_ovf, o1_err_unf, o1_in_isr, o1_depth}); end
    pulse_reti();
    checks++; if ({o0_err_unf, o0_pc_load, o0_s_finished} !== 3'b100) begin failures++; $display("FAIL reset_unf0 got=%b exp=100", {o0_err_unf, o0_pc_load, o0_s_finished}); end
    checks++; if ({o1_err_unf, o1_pc_load, o1_s_finished} !== 3'b100) begin failures++; $display("FAIL reset_unf1 got=%b exp=100", {o1_err_unf, o1_pc_load, o1_s_finished}); end
    cycle();
    checks++; if (o0_err_unf !== 1'b0) begin failures++; $display("FAIL reset_unf_pulse0 got=%b exp=0", o0_err_unf); end
  endtask

  task automatic test_single();
    do_reset();
    pulse_req(10'h012, 10'h050);
    checks++; if ({o0_pc_load, o0_pc_target, o0_depth, o0_in_isr} !== {1'b1, 10'h012, 4'd1, 1'b1}) begin failures++; $display("FAIL single_entry0 load=%b tgt=%h depth=%0d isr=%b exp 1/012/1/1", o0_pc_load, o0_pc_target, o0_depth, o0_in_isr); end
    checks++; if ({o1_pc_load, o1_pc_target, o1_depth} !== {1'b1, 10'h012, 4'd1}) begin failures++; $display("FAIL single_entry1 load=%b tgt=%h depth=%0d exp 1/012/1", o1_pc_load, o1_pc_target, o1_depth); end
    cycle();
    checks++; if ({o0_pc_load, o0_pc_target} !== {1'b0, 10'h012}) begin failures++; $display("FAIL single_hold0 load=%b tgt=%h exp 0/012", o0_pc_load, o0_pc_target); end
    pulse_reti();
    checks++; if ({o0_pc_load, o0_pc_target, o0_s_finished, o0_depth} !== {1'b1, 10'h050, 1'b1, 4'd0}) begin failures++; $display("FAIL single_return0 load=%b tgt=%h fin=%b depth=%0d exp 1/050/1/0", o0_pc_load, o0_pc_target, o0_s_finished, o0_depth); end
    checks++; if ({o1_pc_load, o1_pc_target, o1_s_finished, o1_depth} !== {1'b1, 10'h050, 1'b1, 4'd0}) begin failures++; $display("FAIL single_return1 load=%b tgt=%h fin=%b depth=%0d exp 1/050/1/0", o1_pc_load, o1_pc_target, o1_s_finished, o1_depth); end
    cycle();
    checks++; if ({o0_s_finished, o0_pc_load, o0_pc_target, o0_in_isr} !== {1'b0, 1'b0, 10'h050, 1'b0}) begin failures++; $display("FAIL single_after0 fin=%b load=%b tgt=%h isr=%b exp 0/0/050/0", o0_s_finished, o0_pc_load, o0_pc_target, o0_in_isr); end
  endtask

  task automatic test_pending();
    do_reset();
    pulse_req(10'h030, 10'h080);
    cycle();
    pulse_req(10'h3FC, 10'h090);
    checks++; if ({o0_pc_load, o0_depth} !== {1'b0, 4'd1}) begin failures++; $display("FAIL pend_noload0 load=%b depth=%0d exp 0/1", o0_pc_load, o0_depth); end
    checks++; if ({o1_pc_load, o1_pc_target, o1_depth} !== {1'b1, 10'h3FC, 4'd2}) begin failures++; $display("FAIL pend_nest1 load=%b tgt=%h depth=%0d exp 1/3fc/2", o1_pc_load, o1_pc_target, o1_depth); end
    cycle();
    pc_current = 10'h0A0;
    pulse_reti();
    checks++; if ({o0_pc_load, o0_pc_target, o0_s_finished, o0_depth} !== {1'b1, 10'h080, 1'b1, 4'd0}) begin failures++; $display("FAIL pend_return0 load=%b tgt=%h fin=%b depth=%0d exp 1/080/1/0", o0_pc_load, o0_pc_target, o0_s_finished, o0_depth); end
    pc_current = 10'h0BB;
    cycle();
    checks++; if ({o0_pc_load, o0_s_finished} !== 2'b00) begin failures++; $display("FAIL pend_gap0 load=%b fin=%b exp 0/0", o0_pc_load, o0_s_finished); end
    pc_current = 10'h0C4;
    cycle();
    checks++; if ({o0_pc_load, o0_pc_target, o0_depth} !== {1'b1, 10'h3FC, 4'd1}) begin failures++; $display("FAIL pend_entry0 load=%b tgt=%h depth=%0d exp 1/3fc/1", o0_pc_load, o0_pc_target, o0_depth); end
    pc_current = 10'h3FD;
    cycle();
    pulse_reti();
    checks++; if ({o0_pc_load, o0_pc_target, o0_s_finished} !== {1'b1, 10'h0C4, 1'b1}) begin failures++; $display("FAIL pend_retaddr0 load=%b tgt=%h fin=%b exp 1/0c4/1", o0_pc_load, o0_pc_target, o0_s_finished); end
    cycle();
  endtask

  task automatic test_overflow();
    do_reset();
    pulse_req(10'h111, 10'h010);
    checks++; if ({o1_pc_load, o1_pc_target} !== {1'b1, 10'h111}) begin failures++; $display("FAIL ovf_first1 load=%b tgt=%h exp 1/111", o1_pc_load, o1_pc_target); end
    cycle();
    pulse_req(10'h122, 10'h020);
    checks++; if ({o1_pc_load, o1_pc_target, o1_depth} !== {1'b1, 10'h122, 4'd2}) begin failures++; $display("FAIL ovf_second1 load=%b tgt=%h depth=%0d exp 1/122/2", o1_pc_load, o1_pc_target, o1_depth); end
    cycle();
    pulse_req(10'h133, 10'h030);
    checks++; if ({o1_pc_load, o1_err_ovf, o1_depth} !== {1'b0, 1'b1, 4'd2}) begin failures++; $display("FAIL ovf_third1 load=%b ovf=%b depth=%0d exp 0/1/2", o1_pc_load, o1_err_ovf, o1_depth); end
    cycle();
    checks++; if (o1_err_ovf !== 1'b0) begin failures++; $display("FAIL ovf_pulse1 got=%b exp=0", o1_err_ovf); end
    pulse_reti();
    checks++; if ({o1_pc_load, o1_pc_target, o1_s_finished, o1_depth} !== {1'b1, 10'h020, 1'b1, 4'd1}) begin failures++; $display("FAIL ovf_ret_a1 load=%b tgt=%h fin=%b depth=%0d exp 1/020/1/1", o1_pc_load, o1_pc_target, o1_s_finished, o1_depth); end
    cycle();
    pulse_reti();
    checks++; if ({o1_pc_load, o1_pc_target, o1_depth, o1_in_isr} !== {1'b1, 10'h010, 4'd0, 1'b0}) begin failures++; $display("FAIL ovf_ret_b1 load=%b tgt=%h depth=%0d isr=%b exp 1/010/0/0", o1_pc_load, o1_pc_target, o1_depth, o1_in_isr); end
  endtask

  task automatic test_collision();
    do_reset();
    pulse_req(10'h020, 10'h200);
    cycle();
    s_interruption = 1'b1; i_reti = 1'b1; dir_in = 10'h2AA; pc_current = 10'h300;
    cycle();
    s_interruption = 1'b0; i_reti = 1'b0;
    checks++; if ({o0_pc_load, o0_pc_target, o0_s_finished, o0_depth} !== {1'b1, 10'h200, 1'b1, 4'd0}) begin failures++; $display("FAIL coll_ret0 load=%b tgt=%h fin=%b depth=%0d exp 1/200/1/0", o0_pc_load, o0_pc_target, o0_s_finished, o0_depth); end
    checks++; if ({o1_pc_load, o1_pc_target, o1_s_finished} !== {1'b1, 10'h200, 1'b1}) begin failures++; $display("FAIL coll_ret1 load=%b tgt=%h fin=%b exp 1/200/1", o1_pc_load, o1_pc_target, o1_s_finished); end
    pc_current = 10'h301;
    cycle();
    checks++; if (o0_pc_load !== 1'b0) begin failures++; $display("FAIL coll_gap0 got=%b exp=0", o0_pc_load); end
    cycle();
    checks++; if ({o0_pc_load, o0_pc_target, o0_depth} !== {1'b1, 10'h2AA, 4'd1}) begin failures++; $display("FAIL coll_entry0 load=%b tgt=%h depth=%0d exp 1/2aa/1", o0_pc_load, o0_pc_target, o0_depth); end
    checks++; if ({o1_pc_load, o1_pc_target, o1_depth} !== {1'b1, 10'h2AA, 4'd1}) begin failures++; $display("FAIL coll_entry1 load=%b tgt=%h depth=%0d exp 1/2aa/1", o1_pc_load, o1_pc_target, o1_depth); end
  endtask

  task automatic test_held();
    int loads0, loads1;
    do_reset();
    loads0 = 0; loads1 = 0;
    s_interruption = 1'b1; dir_in = 10'h155; pc_current = 10'h040;
    for (int i = 0; i < 5; i++) begin
      cycle();
      loads0 += int'(o0_pc_load);
      loads1 += int'(o1_pc_load);
    end
    s_interruption = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      loads0 += int'(o0_pc_load);
      loads1 += int'(o1_pc_load);
    end
    checks++; if (loads0 !== 1) begin failures++; $display("FAIL held_loads0 got=%0d exp=1", loads0); end
    checks++; if (loads1 !== 1) begin failures++; $display("FAIL held_loads1 got=%0d exp=1", loads1); end
    checks++; if (o0_depth !== 4'd1) begin failures++; $display("FAIL held_depth0 got=%0d exp=1", o0_depth); end
  endtask

  task automatic test_random();
    logic [18:0] act, exp;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) s_interruption = ~s_interruption;
      i_reti         = ($urandom_range(0, 4) == 0);
      dir_in         = AW'($urandom_range(0, 1023));
      pc_current     = AW'($urandom_range(0, 1023));
      cycle();
      act = {o0_pc_load, o0_pc_target, o0_s_finished, o0_err_ovf, o0_err_unf, o0_in_isr, o0_depth};
      exp = {e_load[0], e_tgt[0], e_fin[0], e_ovf[0], e_unf[0], m_cnt[0] > 0, 4'(m_cnt[0])};
      checks++; if (act !== exp) begin failures++; if (failures < 40) $display("FAIL rand0 cycle=%0d got=%h exp=%h", n, act, exp); end
      act = {o1_pc_load, o1_pc_target, o1_s_finished, o1_err_ovf, o1_err_unf, o1_in_isr, o1_depth};
      exp = {e_load[1], e_tgt[1], e_fin[1], e_ovf[1], e_unf[1], m_cnt[1] > 0, 4'(m_cnt[1])};
      checks++; if (act !== exp) begin failures++; if (failures < 40) $display("FAIL rand1 cycle=%0d got=%h exp=%h", n, act, exp); end
    end
    reset = 1'b0; s_interruption = 1'b0; i_reti = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s_interruption = 1'b0; i_reti = 1'b0;
    dir_in = '0; pc_current = '0;
    test_reset();
    test_single();
    test_pending();
    test_overflow();
    test_collision();
    test_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
